pipelined_adder: RTL and testbench

//  Parametrised, pipelined WIDTH-bit adder/subtractor with carry/borrow-in, built as STAGES ripple chunks.

---
 rtl/alu_pkg.sv | 11 +
 rtl/adder_chunk.sv | 19 +
 rtl/pipelined_adder.sv | 134 +++++++++++++
 tb/tb_pipelined_adder.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU constants for the adder datapath.
// Width defaults and add/sub encodings of the i_sub control bit.
package alu_pkg;

  localparam int ALU_WIDTH  = 32;
  localparam int ALU_STAGES = 4;

  localparam logic ALU_OP_ADD = 1'b0;
  localparam logic ALU_OP_SUB = 1'b1;

endpackage

// File: rtl/adder_chunk.sv
// Combinational CHUNK-bit ripple slice of the pipelined adder.
// Also reports the carry into its MSB for signed overflow.
module adder_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             cmsb
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};

  // Carry into the MSB recovered from the MSB sum bit.
  assign cmsb = a[CHUNK-1] ^ b[CHUNK-1] ^ sum[CHUNK-1];

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit add/sub, one CHUNK slice per stage.
// Valid/ready on both sides; the whole pipe advances as one.
module pipelined_adder
  import alu_pkg::*;
#(
  parameter int WIDTH  = ALU_WIDTH,
  parameter int STAGES = ALU_STAGES
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_c,
  input  logic             i_sub,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_o,
  output logic             o_c,
  output logic             o_v,
  output logic             o_z
);

  localparam int CHUNK = WIDTH / STAGES;
  localparam int L     = STAGES - 1;

  if ((STAGES < 1) || (WIDTH % STAGES != 0)) begin : g_bad_cfg
    $error("pipelined_adder: WIDTH must be a multiple of STAGES");
  end

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             cin;

  logic             vld_q [STAGES];
  logic [WIDTH-1:0] a_q   [STAGES];
  logic [WIDTH-1:0] b_q   [STAGES];
  logic [WIDTH-1:0] s_q   [STAGES];
  logic             cy_q  [STAGES];
  logic             sub_q [STAGES];

  logic             vld_d [STAGES];
  logic [WIDTH-1:0] a_d   [STAGES];
  logic [WIDTH-1:0] b_d   [STAGES];
  logic [WIDTH-1:0] s_d   [STAGES];
  logic [WIDTH-1:0] s_n   [STAGES];
  logic             cy_d  [STAGES];
  logic             sub_d [STAGES];

  logic [CHUNK-1:0] sum_c  [STAGES];
  logic             cout_c [STAGES];
  logic             cm_c   [STAGES];

  logic oc_q;
  logic ov_q;
  logic oz_q;

  assign b_eff = (i_sub == ALU_OP_SUB) ? ~i_b : i_b;
  assign cin   = (i_sub == ALU_OP_ADD) ? i_c : ~i_c;

  assign adv     = ~vld_q[L] | i_ready;
  assign o_ready = adv;
  assign o_valid = vld_q[L];
  assign o_o     = s_q[L];
  assign o_c     = oc_q;
  assign o_v     = ov_q;
  assign o_z     = oz_q;

  // Stage k sees the inputs for k=0, else the skew regs of stage k-1.
  always_comb begin
    vld_d[0] = i_valid;
    a_d[0]   = i_a;
    b_d[0]   = b_eff;
    s_d[0]   = '0;
    cy_d[0]  = cin;
    sub_d[0] = i_sub;
    for (int k = 1; k < STAGES; k++) begin
      vld_d[k] = vld_q[k-1];
      a_d[k]   = a_q[k-1];
      b_d[k]   = b_q[k-1];
      s_d[k]   = s_q[k-1];
      cy_d[k]  = cy_q[k-1];
      sub_d[k] = sub_q[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      s_n[k] = s_d[k];
      s_n[k][k*CHUNK +: CHUNK] = sum_c[k];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    adder_chunk #(
      .CHUNK (CHUNK)
    ) u_chunk (
      .a    (a_d[k][k*CHUNK +: CHUNK]),
      .b    (b_d[k][k*CHUNK +: CHUNK]),
      .cin  (cy_d[k]),
      .sum  (sum_c[k]),
      .cout (cout_c[k]),
      .cmsb (cm_c[k])
    );
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int k = 0; k < STAGES; k++) begin
        vld_q[k] <= 1'b0;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        s_q[k]   <= '0;
        cy_q[k]  <= 1'b0;
        sub_q[k] <= 1'b0;
      end
      oc_q <= 1'b0;
      ov_q <= 1'b0;
      oz_q <= 1'b0;
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        vld_q[k] <= vld_d[k];
        a_q[k]   <= a_d[k];
        b_q[k]   <= b_d[k];
        s_q[k]   <= s_n[k];
        cy_q[k]  <= cout_c[k];
        sub_q[k] <= sub_d[k];
      end
      // Flags are registered with the last slice, so no extra latency.
      oc_q <= (sub_d[L] == ALU_OP_SUB) ? ~cout_c[L] : cout_c[L];
      ov_q <= cout_c[L] ^ cm_c[L];
      oz_q <= (s_n[L] == '0);
    end
  end

endmodule

// File: tb/tb_pipelined_adder.sv
// Randomised scoreboard bench for pipelined_adder.
// Main DUT is 32b/4 stages; two extra instances cover 1 and 32 stages.
module tb_pipelined_adder;

  typedef struct {
    logic [31:0] o;
    logic        c;
    logic        v;
    logic        z;
    int          acc;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        i_valid;
  logic [31:0] i_a;
  logic [31:0] i_b;
  logic        i_c;
  logic        i_sub;
  logic        i_ready;

  logic        o_ready, o_valid, o_c, o_v, o_z;
  logic [31:0] o_o;
  logic        r1_ready, r1_valid, r1_c, r1_v, r1_z;
  logic [31:0] r1_o;
  logic        r32_ready, r32_valid, r32_c, r32_v, r32_z;
  logic [31:0] r32_o;

  exp_t        q[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  bit          no_stall = 1;
  bit          held_ok = 0;
  logic [34:0] held;

  pipelined_adder #(.WIDTH(32), .STAGES(4)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_a(i_a), .i_b(i_b), .i_c(i_c), .i_sub(i_sub), .o_valid(o_valid),
    .i_ready(i_ready), .o_o(o_o), .o_c(o_c), .o_v(o_v), .o_z(o_z)
  );

  pipelined_adder #(.WIDTH(32), .STAGES(1)) dut1 (
    .i_clk(clk), .i_reset_n(rst_n), .i_valid(i_valid), .o_ready(r1_ready),
    .i_a(i_a), .i_b(i_b), .i_c(i_c), .i_sub(i_sub), .o_valid(r1_valid),
    .i_ready(i_ready), .o_o(r1_o), .o_c(r1_c), .o_v(r1_v), .o_z(r1_z)
  );

  pipelined_adder #(.WIDTH(32), .STAGES(32)) dut32 (
    .i_clk(clk), .i_reset_n(rst_n), .i_valid(i_valid), .o_ready(r32_ready),
    .i_a(i_a), .i_b(i_b), .i_c(i_c), .i_sub(i_sub), .o_valid(r32_valid),
    .i_ready(i_ready), .o_o(r32_o), .o_c(r32_c), .o_v(r32_v), .o_z(r32_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(logic [31:0] a, logic [31:0] b,
                                 logic c, logic s);
    exp_t        e;
    logic [32:0] w;
    longint      r;
    if (!s) begin
      w = {1'b0, a} + {1'b0, b} + 33'(c);
      r = longint'($signed(a)) + longint'($signed(b)) + longint'(c);
    end else begin
      w = {1'b0, a} - {1'b0, b} - 33'(c);
      r = longint'($signed(a)) - longint'($signed(b)) - longint'(c);
    end
    e.o   = w[31:0];
    e.c   = w[32];
    e.v   = (r > 64'sd2147483647) || (r < -64'sd2147483648);
    e.z   = (w[31:0] == 32'd0);
    e.acc = 0;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step(input logic v, input logic [31:0] a,
                      input logic [31:0] b, input logic c,
                      input logic s, input logic rdy);
    exp_t e;
    @(negedge clk);
    i_valid = v; i_a = a; i_b = b; i_c = c; i_sub = s; i_ready = rdy;
    #1;
    cyc++;
    chk("o_ready", 64'(o_ready), 64'(!o_valid || rdy));
    if (held_ok) chk("hold", 64'({o_o, o_c, o_v, o_z}), 64'(held));
    held_ok = o_valid && !rdy;
    held = {o_o, o_c, o_v, o_z};
    if (o_valid && rdy) begin
      if (q.size() == 0) begin
        chk("spurious_valid", 64'(o_valid), 64'(0));
      end else begin
        e = q.pop_front();
        chk("result", 64'({o_o, o_c, o_v, o_z}), 64'({e.o, e.c, e.v, e.z}));
        if (no_stall) chk("latency", 64'(cyc - e.acc), 64'(4));
      end
    end
    if (v && o_ready) begin
      e = model(a, b, c, s);
      e.acc = cyc;
      q.push_back(e);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && q.size() != 0; i++) step(0, 0, 0, 0, 0, 1);
    chk("drain_empty", 64'(q.size()), 64'(0));
  endtask

  task automatic op(input logic [31:0] a, input logic [31:0] b,
                    input logic c, input logic s);
    step(1, a, b, c, s, 1);
    drain();
  endtask

  initial begin
    int          lat1;
    int          lat32;
    logic [31:0] o1;
    logic [31:0] o32;

    rst_n = 1'b1;
    i_valid = 0; i_a = 0; i_b = 0; i_c = 0; i_sub = 0; i_ready = 1;
    #1 rst_n = 1'b0;
    #12;
    chk("rst_valid", 64'(o_valid), 64'(0));
    chk("rst_flags", 64'({o_o, o_c, o_v, o_z}), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_ready", 64'(o_ready), 64'(1));

    // directed corner cases, one at a time
    op(32'h0000_FFFF, 32'h0000_0001, 0, 0);
    op(32'hFFFF_FFFF, 32'h0000_0001, 0, 0);
    op(32'h7FFF_FFFF, 32'h0000_0001, 0, 0);
    op(32'h0000_0005, 32'h0000_0007, 0, 1);
    op(32'h0000_0007, 32'h0000_0005, 1, 1);
    op(32'h8000_0000, 32'h0000_0001, 0, 1);
    op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0);

    // back-to-back streaming at full rate
    for (int i = 0; i < 100; i++)
      step(1, $urandom, $urandom, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1);
    drain();

    // random valid and random backpressure
    no_stall = 0;
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 1)), $urandom, $urandom,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)));
    drain();
    no_stall = 1;

    // async reset with ops in flight
    for (int i = 0; i < 5; i++)
      step(1, $urandom, $urandom, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1);
    @(posedge clk);
    #2;
    chk("pre_reset_valid", 64'(o_valid), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 64'(o_valid), 64'(0));
    chk("async_rst_out", 64'({o_o, o_c, o_v, o_z}), 64'(0));
    q.delete();
    held_ok = 0;
    i_valid = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0, 1);
    op(32'h1234_5678, 32'h0FED_CBA9, 0, 0);

    // latency of the 1-stage and 32-stage builds
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    i_valid = 1; i_a = 32'h0000_FFFF; i_b = 32'h1; i_c = 0; i_sub = 0;
    i_ready = 1;
    lat1 = -1; lat32 = -1; o1 = 0; o32 = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (n == 1) i_valid = 0;
      if (lat1 < 0 && r1_valid) begin lat1 = n; o1 = r1_o; end
      if (lat32 < 0 && r32_valid) begin lat32 = n; o32 = r32_o; end
    end
    chk("lat_stages1", 64'(lat1), 64'(1));
    chk("lat_stages32", 64'(lat32), 64'(32));
    chk("sum_stages1", 64'(o1), 64'h0001_0000);
    chk("sum_stages32", 64'(o32), 64'h0001_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
